// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per frame, LSB first, with a two-cycle
// done pulse whose second cycle already reports ready to the feeder.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic [7:0] data_Byte,
    input  logic       r_ready,
    input  logic       i_Tx_DV,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done,
    output logic       o_Tx_ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE1,
        DONE2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic             bit_end;
    logic             serial_n, active_n, done_n, ready_n;

    // Next-state logic; outputs are decoded from the next state so that the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        tx_byte_n = tx_byte;
        bit_end   = (clk_cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (i_Tx_DV && r_ready) begin
                    tx_byte_n = data_Byte;
                    bit_idx_n = 3'd0;
                    clk_cnt_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    state_n   = DONE1;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DONE1:   state_n = DONE2;
            DONE2:   state_n = IDLE;
            default: state_n = IDLE;
        endcase

        serial_n = 1'b1;
        active_n = 1'b0;
        done_n   = 1'b0;
        ready_n  = 1'b0;
        case (state_n)
            IDLE:  ready_n = 1'b1;
            START: begin
                serial_n = 1'b0;
                active_n = 1'b1;
            end
            DATA: begin
                serial_n = tx_byte_n[bit_idx_n];
                active_n = 1'b1;
            end
            STOP:  active_n = 1'b1;
            DONE1: done_n = 1'b1;
            DONE2: begin
                done_n  = 1'b1;
                ready_n = 1'b1;
            end
            default: ready_n = 1'b1;
        endcase
    end

    // State, counters, latched byte and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            tx_byte     <= 8'd0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            o_Tx_ready  <= 1'b1;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            tx_byte     <= tx_byte_n;
            o_Tx_Serial <= serial_n;
            o_Tx_Active <= active_n;
            o_Tx_Done   <= done_n;
            o_Tx_ready  <= ready_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, hand-written frame
// sequences and randomized traffic against a timing-arithmetic model.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_ready = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] data = 8'h00;
    logic       act, ser, done, rdy;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .rst        (rst),
        .data_Byte  (data),
        .r_ready    (r_ready),
        .i_Tx_DV    (dv),
        .o_Tx_Active(act),
        .o_Tx_Serial(ser),
        .o_Tx_Done  (done),
        .o_Tx_ready (rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    // Reference model: last accepted frame (edge number and byte).
    int         ecyc = 0;
    bit         m_have = 1'b0;
    int         m_n = 0;
    logic [7:0] m_b = 8'h00;

    // Line decoder and statistics.
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rxq[$];
    int         starts[$];
    int         act_cnt = 0;
    int         done_cnt = 0;
    logic [1:0] done_rdy = 2'b00;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic       rr;
        logic [7:0] data;
        logic [3:0] exp; // {serial, active, done, ready}
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] msg[12];

    // Expected {serial, active, done, ready} d cycles after the accepting edge.
    function automatic logic [3:0] ref_out(int d, logic [7:0] b);
        int k;
        if (d < FRAME) begin
            k = d / CPB;
            if (k == 0) return 4'b0100;
            if (k == 9) return 4'b1100;
            return {b[k-1], 3'b100};
        end
        if (d == FRAME)     return 4'b1010;
        if (d == FRAME + 1) return 4'b1011;
        return 4'b1001;
    endfunction

    task automatic chk(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, ecyc);
        end
    endtask

    task automatic step();
        logic [3:0] e;
        int k;
        @(posedge clk);
        ecyc++;
        if (rst) m_have = 1'b0;
        else if (dv && r_ready && (!m_have || ecyc - 1 - m_n >= FRAME + 2)) begin
            m_have = 1'b1;
            m_n    = ecyc;
            m_b    = data;
        end
        e = m_have ? ref_out(ecyc - m_n, m_b) : 4'b1001;
        #1;
        chk("model_out", {28'd0, ser, act, done, rdy}, {28'd0, e});
        if (act) act_cnt++;
        if (done) begin
            done_cnt++;
            done_rdy = {done_rdy[0], rdy};
        end
        if (rst) rx_busy = 1'b0;
        else if (!rx_busy) begin
            if (ser == 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
                starts.push_back(ecyc);
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                k = rx_t / CPB;
                if (k >= 1 && k <= 8) rx_sh[k-1] = ser;
                else if (k == 9) begin
                    chk("stop_bit", {31'd0, ser}, 32'd1);
                    rxq.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(int n);
        dv = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int idx;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A};
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'b1001};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'b1001};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h12, 4'b1001};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h34, 4'b1001};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'hAA, 4'b1001};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h48, 4'b0100};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'b0100};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'b1001};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'b1001};

        // Vector table: reset, refused requests, accept, reset abort.
        for (int i = 0; i < 9; i++) begin
            rst     = tbl[i].rst;
            dv      = tbl[i].dv;
            r_ready = tbl[i].rr;
            data    = tbl[i].data;
            step();
            chk($sformatf("vec%0d", i), {28'd0, ser, act, done, rdy}, {28'd0, tbl[i].exp});
        end

        // Hold idle with requests while receiver not ready.
        rst = 1'b0;
        starts.delete();
        done_cnt = 0;
        dv = 1'b1;
        r_ready = 1'b0;
        repeat (12) step();
        idle(5);
        chk("idle_no_start", starts.size(), 0);
        chk("idle_no_done", done_cnt, 0);

        // Single frame 0x48, receiver-ready dropped mid-frame.
        rxq.delete();
        act_cnt = 0; done_cnt = 0; done_rdy = 2'b00;
        data = 8'h48; dv = 1'b1; r_ready = 1'b1;
        step();
        dv = 1'b0; r_ready = 1'b0; data = 8'hFF;
        repeat (FRAME + 4) step();
        chk("single_active_cycles", act_cnt, 40);
        chk("single_done_cycles", done_cnt, 2);
        chk("single_done_ready", {30'd0, done_rdy}, 32'd1);
        chk("single_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("single_rx_byte", {24'd0, rxq[0]}, 32'h48);

        // Feeder-style handshake over "Hello World\n".
        rxq.delete();
        idx = 0;
        r_ready = 1'b1;
        for (int c = 0; c < 12 * (FRAME + 3) + 20 && idx < 12; c++) begin
            data = msg[idx];
            dv = 1'b1;
            step();
            if (done && !rdy) idx++;
        end
        chk("hello_progress", idx, 12);
        idle(10);
        chk("hello_rx_count", rxq.size(), 12);
        for (int i = 0; i < 12 && i < rxq.size(); i++)
            chk($sformatf("hello_byte%0d", i), {24'd0, rxq[i]}, {24'd0, msg[i]});

        // Busy rejection: request and new data held through the whole frame.
        idle(3);
        rxq.delete(); starts.delete();
        data = 8'hA5; dv = 1'b1; r_ready = 1'b1;
        step();
        data = 8'h3C;
        repeat (FRAME + 2) step();
        idle(FRAME + 5);
        chk("busy_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("busy_rx_byte", {24'd0, rxq[0]}, 32'hA5);
        chk("busy_starts", starts.size(), 1);

        // Reset during data bit 3 of 0xFF, then a clean 0x55 frame.
        rxq.delete();
        data = 8'hFF; dv = 1'b1; r_ready = 1'b1;
        step();
        dv = 1'b0;
        repeat (4 * CPB + 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_out", {28'd0, ser, act, done, rdy}, 32'h9);
        done_cnt = 0;
        idle(FRAME + 5);
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_no_byte", rxq.size(), 0);
        data = 8'h55; dv = 1'b1;
        step();
        idle(FRAME + 4);
        chk("rst_after_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("rst_after_rx_byte", {24'd0, rxq[0]}, 32'h55);

        // Continuous request: back-to-back frames 0x00 then 0xFF.
        rxq.delete(); starts.delete();
        data = 8'h00; dv = 1'b1; r_ready = 1'b1;
        step();
        data = 8'hFF;
        for (int c = 0; c < 100 && starts.size() < 2; c++) step();
        idle(FRAME + 5);
        chk("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) chk("b2b_period", starts[1] - starts[0], FRAME + 3);
        chk("b2b_rx_count", rxq.size(), 2);
        if (rxq.size() >= 2) begin
            chk("b2b_byte0", {24'd0, rxq[0]}, 32'h00);
            chk("b2b_byte1", {24'd0, rxq[1]}, 32'hFF);
        end

        // Randomized traffic, including occasional resets.
        repeat (3000) begin
            rst     = ($urandom_range(0, 199) == 0);
            dv      = ($urandom_range(0, 3) != 0);
            r_ready = ($urandom_range(0, 3) != 0);
            data    = 8'($urandom);
            step();
        end
        rst = 1'b0;
        idle(FRAME + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
